// File: rtl/timebase_pkg.sv
package timebase_pkg;

  localparam int unsigned US_PER_MS_DEF = 1000;
  localparam int unsigned MS_PER_S_DEF  = 1000;

  // Returns ceil(log2(v)), never less than 1 so that a modulus-1 counter still has a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 1) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/timebase_gen_if.sv
interface timebase_gen_if #(
  parameter int unsigned PRG_W = 16
);

  logic             en;
  logic [PRG_W-1:0] prg_period;
  logic             prg_load;
  logic             pluse_us;
  logic             pluse_ms;
  logic             pluse_s;
  logic             pluse_prg;
  logic             rst_hold_n;

  modport master (
    output en, prg_period, prg_load,
    input  pluse_us, pluse_ms, pluse_s, pluse_prg, rst_hold_n
  );

  modport slave (
    input  en, prg_period, prg_load,
    output pluse_us, pluse_ms, pluse_s, pluse_prg, rst_hold_n
  );

endinterface

// File: rtl/timebase_gen_mod_cnt.sv
module mod_cnt
  import timebase_pkg::*;
#(
  parameter int unsigned MOD = 2,
  parameter int unsigned W   = clog2(MOD),
  parameter bit          DYN = 1'b0
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] mod_in,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] last;
  logic         live;

  if (DYN) begin : g_dyn
    // A zero runtime modulus parks the counter at 0 and never wraps.
    assign last = mod_in - W'(1);
    assign live = |mod_in;
  end else begin : g_fix
    logic unused_mod;
    assign unused_mod = ^mod_in;
    assign last       = W'(MOD - 1);
    assign live       = 1'b1;
  end

  assign wrap = inc & live & (cnt == last);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && live) begin
      cnt <= (cnt == last) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timebase_gen.sv
module timebase_gen
  import timebase_pkg::*;
#(
  parameter int unsigned CLK_MHZ     = 100,
  parameter int unsigned US_PER_MS   = US_PER_MS_DEF,
  parameter int unsigned MS_PER_S    = MS_PER_S_DEF,
  parameter int unsigned PRG_W       = 16,
  parameter int unsigned RST_HOLD_US = 10
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PRG_W-1:0] prg_period,
  input  logic             prg_load,
  output logic             pluse_us,
  output logic             pluse_ms,
  output logic             pluse_s,
  output logic             pluse_prg,
  output logic             rst_hold_n
);

  localparam int unsigned PRE_W  = clog2(CLK_MHZ);
  localparam int unsigned MS_W   = clog2(US_PER_MS);
  localparam int unsigned S_W    = clog2(MS_PER_S);
  localparam int unsigned HOLD_W = clog2(RST_HOLD_US + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_US);

  logic [PRE_W-1:0]  pre_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic [S_W-1:0]    s_cnt;
  logic [PRG_W-1:0]  prg_cnt;
  logic [PRG_W-1:0]  prg_p;
  logic [HOLD_W-1:0] hold_cnt;

  logic raw_tick;
  logic tick_en;
  logic ms_wrap;
  logic s_wrap;
  logic prg_wrap;

  // Wraps drive the cascade; the counts themselves are not needed at this level.
  logic unused_cnt;
  assign unused_cnt = ^{pre_cnt, ms_cnt, s_cnt, prg_cnt};

  assign tick_en = raw_tick & en;

  mod_cnt #(
    .MOD (CLK_MHZ),
    .W   (PRE_W)
  ) u_pre (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (1'b0),
    .inc     (1'b1),
    .mod_in  ('0),
    .cnt     (pre_cnt),
    .wrap    (raw_tick)
  );

  mod_cnt #(
    .MOD (US_PER_MS),
    .W   (MS_W)
  ) u_ms (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (1'b0),
    .inc     (tick_en),
    .mod_in  ('0),
    .cnt     (ms_cnt),
    .wrap    (ms_wrap)
  );

  mod_cnt #(
    .MOD (MS_PER_S),
    .W   (S_W)
  ) u_s (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (1'b0),
    .inc     (ms_wrap),
    .mod_in  ('0),
    .cnt     (s_cnt),
    .wrap    (s_wrap)
  );

  mod_cnt #(
    .MOD (2),
    .W   (PRG_W),
    .DYN (1'b1)
  ) u_prg (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (prg_load),
    .inc     (tick_en),
    .mod_in  (prg_p),
    .cnt     (prg_cnt),
    .wrap    (prg_wrap)
  );

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      pluse_us   <= 1'b0;
      pluse_ms   <= 1'b0;
      pluse_s    <= 1'b0;
      pluse_prg  <= 1'b0;
      prg_p      <= '0;
      hold_cnt   <= '0;
      rst_hold_n <= 1'b0;
    end else begin
      pluse_us  <= tick_en;
      pluse_ms  <= ms_wrap;
      pluse_s   <= s_wrap;
      // A load on a tick restarts the period, so that tick must not fire the old one.
      pluse_prg <= prg_wrap & ~prg_load;
      if (prg_load) begin
        prg_p <= prg_period;
      end
      if (raw_tick && (hold_cnt != HOLD_LAST)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      rst_hold_n <= (hold_cnt == HOLD_LAST);
    end
  end

endmodule

// File: tb/tb_timebase_gen.sv
module tb_timebase_gen;

  localparam int unsigned CLK_MHZ   = 4;
  localparam int unsigned US_PER_MS = 5;
  localparam int unsigned MS_PER_S  = 3;
  localparam int unsigned PRG_W     = 8;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  int unsigned cyc;
  int unsigned total = 0;
  int unsigned bad   = 0;

  timebase_gen_if #(.PRG_W(PRG_W)) tb_if ();

  logic b_us, b_ms, b_s, b_prg, b_hold_n;

  always #5 clk_sys = ~clk_sys;

  timebase_gen #(
    .CLK_MHZ     (CLK_MHZ),
    .US_PER_MS   (US_PER_MS),
    .MS_PER_S    (MS_PER_S),
    .PRG_W       (PRG_W),
    .RST_HOLD_US (2)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .en         (tb_if.en),
    .prg_period (tb_if.prg_period),
    .prg_load   (tb_if.prg_load),
    .pluse_us   (tb_if.pluse_us),
    .pluse_ms   (tb_if.pluse_ms),
    .pluse_s    (tb_if.pluse_s),
    .pluse_prg  (tb_if.pluse_prg),
    .rst_hold_n (tb_if.rst_hold_n)
  );

  timebase_gen #(
    .CLK_MHZ     (CLK_MHZ),
    .US_PER_MS   (US_PER_MS),
    .MS_PER_S    (MS_PER_S),
    .PRG_W       (PRG_W),
    .RST_HOLD_US (0)
  ) dut_h0 (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .en         (tb_if.en),
    .prg_period (tb_if.prg_period),
    .prg_load   (tb_if.prg_load),
    .pluse_us   (b_us),
    .pluse_ms   (b_ms),
    .pluse_s    (b_s),
    .pluse_prg  (b_prg),
    .rst_hold_n (b_hold_n)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input logic e_us, input logic e_ms, input logic e_s,
                           input logic e_prg, input logic e_hold, input logic e_hold0);
    check("us",       tb_if.pluse_us,   e_us);
    check("ms",       tb_if.pluse_ms,   e_ms);
    check("s",        tb_if.pluse_s,    e_s);
    check("prg",      tb_if.pluse_prg,  e_prg);
    check("hold_n",   tb_if.rst_hold_n, e_hold);
    check("h0_us",    b_us,             e_us);
    check("h0_ms",    b_ms,             e_ms);
    check("h0_s",     b_s,              e_s);
    check("h0_prg",   b_prg,            e_prg);
    check("h0_hold_n", b_hold_n,        e_hold0);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    tb_if.en         = 1'b0;
    tb_if.prg_load   = 1'b0;
    tb_if.prg_period = '0;
    repeat (3) step();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // Power-up: tick cascade, prg P=3 loaded at cycle 2, hold release at cycle 9.
    do_reset();
    check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tb_if.en = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      step();
      check_all(cyc % 4 == 0, cyc % 20 == 0, cyc == 60, cyc % 12 == 0, cyc >= 9, 1'b1);
      tb_if.prg_load   = (cyc == 1);
      tb_if.prg_period = 8'd3;
    end

    // Reset mid-operation at cycle 37 must clear counters and the prg period.
    do_reset();
    tb_if.en         = 1'b1;
    tb_if.prg_period = 8'd1;
    tb_if.prg_load   = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      step();
      tb_if.prg_load = 1'b0;
      check_all(cyc % 4 == 0, cyc % 20 == 0, 1'b0, cyc % 4 == 0, cyc >= 9, 1'b1);
    end
    rst_n = 1'b0;
    step();
    check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc   = 0;
    for (int c = 1; c <= 24; c++) begin
      step();
      check_all(cyc % 4 == 0, cyc % 20 == 0, 1'b0, 1'b0, cyc >= 9, 1'b1);
    end

    // en low for edges 10..16: ticks at 12 and 16 are dropped, ms count holds.
    do_reset();
    tb_if.en = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      step();
      check_all((cyc % 4 == 0) && (cyc != 12) && (cyc != 16),
                (cyc == 28) || (cyc == 48), 1'b0, 1'b0, cyc >= 9, 1'b1);
      tb_if.en = !((cyc >= 9) && (cyc <= 15));
    end

    // en low from release: no ticks, hold release unaffected.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step();
      check_all(1'b0, 1'b0, 1'b0, 1'b0, cyc >= 9, 1'b1);
    end

    // prg: load on a raw tick (edge 4), reload mid-period (22), P=0 (41), P=1 (142).
    do_reset();
    tb_if.en         = 1'b1;
    tb_if.prg_period = 8'd3;
    for (int c = 1; c <= 160; c++) begin
      step();
      check_all(cyc % 4 == 0, cyc % 20 == 0, cyc % 60 == 0,
                (cyc == 16) || (cyc == 32) || ((cyc >= 144) && (cyc % 4 == 0)),
                cyc >= 9, 1'b1);
      tb_if.prg_load   = (cyc == 3) || (cyc == 21) || (cyc == 40) || (cyc == 141);
      tb_if.prg_period = (cyc < 40) ? 8'd3 : ((cyc < 141) ? 8'd0 : 8'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
